// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: two-entry skid buffer between pipeline stages.
// Carries a WIDTH-bit payload with valid/ready, flush and stall counter.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   flush              squash held and incoming entries
//   in_valid/in_ready  upstream handshake, in_data payload
//   out_valid/out_ready downstream handshake, out_data head payload
//   clr_cnt            clear stall counter
//   stall_cnt          saturating count of stalled cycles

module pipe_stage_buf #(
    parameter int WIDTH = 102,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_fire;
    logic             out_fire;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL);
    assign out_data  = m_q;
    assign stall_cnt = cnt_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    m_d     = in_data;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    m_d = in_data;
                end else if (in_fire) begin
                    state_d = FULL;
                    s_d     = in_data;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d = ONE;
                    m_d     = s_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Storage is don't-care once invalid, so flush only drops state.
        if (flush) begin
            state_d = EMPTY;
            m_d     = m_q;
            s_d     = s_q;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (out_valid && !out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            m_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed checks of the skid buffer.
// Streaming, back-pressure, flush, counter saturation and reset.

module tb_pipe_stage_buf;

    localparam int W  = 102;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          clr_cnt = 1'b0;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    pipe_stage_buf #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .clr_cnt   (clr_cnt),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input logic v,
                        input logic r, input logic [W-1:0] d);
        chk({tag, ".valid"}, 128'(out_valid), 128'(v));
        chk({tag, ".ready"}, 128'(in_ready), 128'(r));
        if (v) chk({tag, ".data"}, 128'(out_data), 128'(d));
    endtask

    initial begin
        // Reset state before any clock.
        #2;
        outs("rst", 1'b0, 1'b1, '0);
        chk("rst.data0", 128'(out_data), 128'd0);
        chk("rst.cnt", 128'(stall_cnt), 128'd0);
        #5 rst_n = 1'b1;

        // Streaming at full rate.
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = W'(1);
        step(); outs("str1", 1'b1, 1'b1, W'(1));
        in_data = W'(2);
        step(); outs("str2", 1'b1, 1'b1, W'(2));
        in_data = W'(3);
        step(); outs("str3", 1'b1, 1'b1, W'(3));
        in_valid = 1'b0;
        step(); outs("str4", 1'b0, 1'b1, '0);
        chk("str.cnt", 128'(stall_cnt), 128'd0);

        // Skid fill then drain.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'('hA);
        step(); outs("skA", 1'b1, 1'b1, W'('hA));
        in_data = W'('hB);
        step(); outs("skB", 1'b1, 1'b0, W'('hA));
        chk("sk.cnt1", 128'(stall_cnt), 128'd1);
        in_data = W'('hC);
        step(); outs("skC", 1'b1, 1'b0, W'('hA));
        chk("sk.cnt2", 128'(stall_cnt), 128'd2);
        out_ready = 1'b1;
        step(); outs("drB", 1'b1, 1'b1, W'('hB));
        chk("dr.cnt", 128'(stall_cnt), 128'd2);
        step(); outs("drC", 1'b1, 1'b1, W'('hC));
        in_valid = 1'b0;
        step(); outs("drE", 1'b0, 1'b1, '0);

        // Counter saturation and clear.
        clr_cnt = 1'b1;
        step(); chk("clr0", 128'(stall_cnt), 128'd0);
        clr_cnt   = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'('h5);
        step(); outs("c5", 1'b1, 1'b1, W'('h5));
        chk("c.cnt0", 128'(stall_cnt), 128'd0);
        in_valid = 1'b0;
        step(); chk("cnt1", 128'(stall_cnt), 128'd1);
        step(); chk("cnt2", 128'(stall_cnt), 128'd2);
        step(); chk("cnt3", 128'(stall_cnt), 128'd3);
        step(); chk("cnt4", 128'(stall_cnt), 128'd3);
        step(); chk("cnt5", 128'(stall_cnt), 128'd3);
        step(); chk("cnt6", 128'(stall_cnt), 128'd3);
        clr_cnt = 1'b1;
        step(); chk("cntclr", 128'(stall_cnt), 128'd0);
        clr_cnt = 1'b0;
        outs("c5h", 1'b1, 1'b1, W'('h5));

        // Flush in ONE with in_fire and out_fire.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = W'('h6);
        flush     = 1'b1;
        step(); outs("f1", 1'b0, 1'b1, '0);
        flush    = 1'b0;
        in_valid = 1'b0;
        step(); outs("f1b", 1'b0, 1'b1, '0);
        chk("f1.cnt", 128'(stall_cnt), 128'd0);

        // Flush in FULL with a simultaneous offer.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'('h7);
        step(); outs("f2a", 1'b1, 1'b1, W'('h7));
        in_data = W'('h8);
        step(); outs("f2b", 1'b1, 1'b0, W'('h7));
        in_data = W'('h9);
        flush   = 1'b1;
        step(); outs("f2", 1'b0, 1'b1, '0);
        chk("f2.cnt", 128'(stall_cnt), 128'd2);
        flush    = 1'b0;
        in_valid = 1'b0;
        step(); outs("f2c", 1'b0, 1'b1, '0);
        chk("f2c.cnt", 128'(stall_cnt), 128'd2);

        // Async reset while FULL.
        in_valid = 1'b1;
        in_data  = W'('h11);
        step(); outs("r11", 1'b1, 1'b1, W'('h11));
        in_data = W'('h22);
        step(); outs("r22", 1'b1, 1'b0, W'('h11));
        chk("r.cnt", 128'(stall_cnt), 128'd3);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        outs("rmid", 1'b0, 1'b1, '0);
        chk("rmid.data0", 128'(out_data), 128'd0);
        chk("rmid.cnt", 128'(stall_cnt), 128'd0);
        #1 rst_n = 1'b1;
        step(); outs("rpost", 1'b0, 1'b1, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised inter-stage pipeline buffer for the pipelined datapath. It is the general successor to the fixed EX/MEM latch and carries an arbitrary-width payload bundle (adder, zero flag, ALU result, RD2, destination register; 102 bits by default). On top of the latch it adds a valid/ready handshake, a two-entry skid so that back-pressure costs no throughput, a synchronous flush for branch/hazard squash, and a saturating stall counter for performance debug.

## Interface
- `WIDTH`, 102: payload width in bits, ≥1.
- `CNT_W`, 16: stall counter width, ≥1.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous squash of all held and incoming entries.
- `in_valid`  in  1  upstream stage presents data.
- `in_ready`  out  1  buffer can accept data; a function of registered state only.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  `out_data` holds a valid entry.
- `out_ready`  in  1  downstream stage accepts.
- `out_data`  out  WIDTH  head payload, driven directly from the main register.
- `clr_cnt`  in  1  synchronous clear of `stall_cnt`.
- `stall_cnt`  out  CNT_W  cycles with `out_valid && !out_ready`, saturating.

## Operation
- Storage: main register M (head) and skid register S. State is one of EMPTY, ONE or FULL.
- `out_valid` = (state != EMPTY). `out_data` = M. `in_ready` = (state != FULL).
- in_fire = `in_valid && in_ready`. out_fire = `out_valid && out_ready`.
- Transitions when `flush` = 0:
  - EMPTY: in_fire → ONE, M ← `in_data`. Otherwise stay in EMPTY.
  - ONE: in_fire with out_fire → ONE, M ← `in_data`.
  - ONE: in_fire only → FULL, S ← `in_data`.
  - ONE: out_fire only → EMPTY.
  - ONE: neither → hold.
  - FULL: out_fire → ONE, M ← S. Otherwise hold. No in_fire is possible in FULL.
- Flush (priority over everything else):
  - Next state is EMPTY.
  - A handshake completing in the same cycle is accepted and its data is discarded.
  - An out_fire in the same cycle still counts as consumed downstream.
  - M and S contents are not modified, because they are don't-care when invalid.
- Ordering: strict FIFO. Data accepted first leaves first. No payload bit is altered.
- Stall counter:
  - Increments by 1 on every cycle with `out_valid && !out_ready`.
  - Saturates at 2^CNT_W−1 and never wraps.
  - `clr_cnt` forces 0 on the next edge and wins over a simultaneous increment.
  - `flush` does not affect the counter.

## Timing
- Reset (asynchronous assert, takes effect immediately):
  - State is EMPTY.
  - M, S and `stall_cnt` are 0.
  - Outputs: `out_valid` = 0, `out_data` = 0, `in_ready` = 1, `stall_cnt` = 0.
- Reset deassertion: the first active edge is the first edge after `rst_n` rises. Deassertion must be synchronised outside this block.
- Latency: data accepted at edge N appears on `out_data` with `out_valid` = 1 after edge N, i.e. one cycle.
- Throughput: one transfer per cycle sustained when `out_ready` = 1.
- Back-pressure:
  - With `out_ready` held at 0, the buffer accepts at most two entries.
  - `in_ready` falls in the cycle after the second accept.
  - `in_ready` rises again in the cycle after the first out_fire from FULL.
- No combinational path exists from `out_ready` or `in_valid` to `in_ready`.
- No combinational path exists from any input to `out_valid` or `out_data`.
- `stall_cnt` updates on the same edge as the stalled cycle it counts.

## Test plan
- Reset mid-traffic: assert `rst_n` = 0 while in FULL → immediately `out_valid` = 0, `in_ready` = 1, `out_data` = 0, `stall_cnt` = 0, with no clock needed.
- Streaming: send 0x1, 0x2, 0x3 on consecutive cycles with `out_ready` = 1 → outputs 0x1, 0x2, 0x3 on the following consecutive cycles; `in_ready` stays 1; `stall_cnt` = 0.
- Skid fill and drain:
  - Hold `out_ready` = 0 and offer 0xA, 0xB, 0xC.
  - Required: 0xA and 0xB accepted, `in_ready` = 0, 0xC held upstream.
  - Then raise `out_ready`. Required: output order 0xA, 0xB, 0xC with no bubble after 0xA.
- Flush in FULL with a simultaneous offer: state FULL, `flush` = 1, `in_valid` = 1 → next cycle `out_valid` = 0, state EMPTY, `in_ready` = 1, and the offered data never appears.
- Flush in ONE with simultaneous in_fire and out_fire: head 0x5 consumed, new 0x6 offered with `flush` = 1 → next cycle `out_valid` = 0 and 0x6 is dropped.
- Counter:
  - With `CNT_W` = 2, stall for 6 cycles → `stall_cnt` counts 1, 2, 3, 3, 3, 3.
  - Then `clr_cnt` = 1 during a stalled cycle → `stall_cnt` = 0 on the next edge.
